alu_mdu_seq: RTL and testbench

Parametrised successor to the single-cycle registered ALU. It adds valid/ready handshakes on input and output, an XLEN parameter, and an iterative multiply/divide datapath covering the full RV32M op set. It sits in the execute stage. Base integer ops complete in 1 cycle; M-extension ops occupy the unit for a fixed XLEN+1 cycles.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/mdu_iter.sv | 92 +++++++++
 rtl/alu_mdu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the execute-stage ALU/MDU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SRL    = 5'd3,
    OP_SRA    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_XOR    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASS_B = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } alu_state_e;

  // M-extension group marker (codes 16..31); legality is checked separately.
  function automatic logic is_mop(input logic [4:0] op);
    return op[4];
  endfunction

  // Defined codes are 0..10 and 16..23.
  function automatic logic is_defined(input logic [4:0] op);
    return op[4] ? (op[3] == 1'b0) : (op <= 5'd10);
  endfunction

  // Within the M group, bit 2 separates divide/remainder from multiply.
  function automatic logic is_div_op(input logic [4:0] op);
    return op[2];
  endfunction

  function automatic logic a_is_signed(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide core: one radix-2 step per cycle, XLEN steps per op.
// Multiply: acc = {hi, lo} with lo holding the multiplier; result is the full product.
// Divide (restoring): acc = {remainder, quotient}; lo starts as the dividend.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              done,
  output logic [2*XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              div_q, div_d;
  logic              run_q, run_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic              last;

  assign last   = run_q && (cnt_q == CW'(XLEN - 1));
  assign done   = last;
  assign result = acc_q;

  // One shift-add or shift-subtract step on the shared accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, dvs_q};
    if (div_q) begin
      if (!div_diff[XLEN]) begin
        acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Load on start, iterate while running, stop after the XLEN-th step.
  always_comb begin
    acc_d = acc_q;
    dvs_d = dvs_q;
    div_d = div_q;
    run_d = run_q;
    cnt_d = cnt_q;
    if (flush) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      acc_d = {{XLEN{1'b0}}, op_a};
      dvs_d = op_b;
      div_d = is_div;
      run_d = 1'b1;
      cnt_d = '0;
    end else if (run_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      dvs_q <= '0;
      div_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      div_q <= div_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle base ops and
// fixed-latency (XLEN+1) RV32M ops through the iterative mdu_iter core.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_s,
  output logic            out_illegal,
  output logic            busy
);

  alu_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_s_q, out_s_d;
  logic              out_illegal_q, out_illegal_d;
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic              neg_q, neg_d;
  logic              bzero_q, bzero_d;

  logic              accept;
  logic              m_start;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res;
  logic              neg_a, neg_b, res_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              mdu_done;
  logic [2*XLEN-1:0] mdu_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fin_res;

  assign accept  = in_valid && in_ready;
  assign m_start = accept && is_mop(in_op) && is_defined(in_op);

  assign out_valid   = out_valid_q;
  assign out_s       = out_s_q;
  assign out_illegal = out_illegal_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush overrides everything; CALC lasts until the core's last step.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (m_start) state_d = CALC;
        CALC:    if (mdu_done) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: accept only when idle, the result slot is free, and not flushing.
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    busy     = (state_q != IDLE);
  end

  // Single-cycle base-op datapath; undefined codes yield zero.
  always_comb begin
    base_res = '0;
    shamt    = in_b[SHW-1:0];
    case (in_op)
      OP_ADD:    base_res = in_a + in_b;
      OP_SUB:    base_res = in_a - in_b;
      OP_SLL:    base_res = in_a << shamt;
      OP_SRL:    base_res = in_a >> shamt;
      OP_SRA:    base_res = $signed(in_a) >>> shamt;
      OP_SLT:    base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU:   base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      OP_XOR:    base_res = in_a ^ in_b;
      OP_OR:     base_res = in_a | in_b;
      OP_AND:    base_res = in_a & in_b;
      OP_PASS_B: base_res = in_b;
      default:   base_res = '0;
    endcase
  end

  // Operand magnitudes and result sign for the unsigned iterative core.
  // Signed remainder takes the dividend's sign; everything else takes the xor.
  always_comb begin
    neg_a   = a_is_signed(in_op) && in_a[XLEN-1];
    neg_b   = b_is_signed(in_op) && in_b[XLEN-1];
    mag_a   = neg_a ? -in_a : in_a;
    mag_b   = neg_b ? -in_b : in_b;
    res_neg = (in_op == OP_REM) ? neg_a : (neg_a ^ neg_b);
  end

  mdu_iter #(
    .XLEN (XLEN)
  ) u_mdu_iter (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (m_start),
    .is_div (is_div_op(in_op)),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .done   (mdu_done),
    .result (mdu_res)
  );

  // Sign fix-up and result select for the finished M op; divide-by-zero overrides.
  always_comb begin
    prod_fix = neg_q ? -mdu_res : mdu_res;
    quo_fix  = neg_q ? -mdu_res[XLEN-1:0] : mdu_res[XLEN-1:0];
    rem_fix  = neg_q ? -mdu_res[2*XLEN-1:XLEN] : mdu_res[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fin_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin_res = bzero_q ? '1 : quo_fix;
      default:                       fin_res = bzero_q ? a_q : rem_fix;
    endcase
  end

  // Result slot and latched M-op context: retire on out_ready, load on base accept or FIN.
  always_comb begin
    out_valid_d   = out_valid_q && !out_ready;
    out_s_d       = out_s_q;
    out_illegal_d = out_illegal_q;
    op_d          = op_q;
    a_d           = a_q;
    neg_d         = neg_q;
    bzero_d       = bzero_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (state_q == FIN) begin
      out_valid_d   = 1'b1;
      out_s_d       = fin_res;
      out_illegal_d = 1'b0;
    end else if (m_start) begin
      op_d    = in_op;
      a_d     = in_a;
      neg_d   = res_neg;
      bzero_d = (in_b == '0);
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_s_d       = is_defined(in_op) ? base_res : '0;
      out_illegal_d = !is_defined(in_op);
    end
  end

  // Result and context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_s_q       <= '0;
      out_illegal_q <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      neg_q         <= 1'b0;
      bzero_q       <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_s_q       <= out_s_d;
      out_illegal_q <= out_illegal_d;
      op_q          <= op_d;
      a_q           <= a_d;
      neg_q         <= neg_d;
      bzero_q       <= bzero_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: base-op pipelining, M-op latency and results,
// divide corner cases, backpressure, flush, mid-op reset and illegal codes.
module tb_alu_mdu_seq;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_s;
  logic            out_illegal;
  logic            busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  alu_mdu_seq #(
    .XLEN (XLEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one base op and check its result one edge later.
  task automatic base_op(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input logic ill);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    check({tag, "/valid"}, XLEN'(out_valid), 32'h1);
    check(tag, out_s, exp);
    check({tag, "/illegal"}, XLEN'(out_illegal), XLEN'(ill));
  endtask

  // Issue one M op; expect busy through the iterations and the result at accept+33.
  task automatic run_mop(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    int lat;
    int busy_bad;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    check({tag, "/busy_acc"}, XLEN'(busy), 32'h1);
    lat      = 0;
    busy_bad = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      if (!out_valid && (!busy || in_ready)) busy_bad++;
    end
    check({tag, "/latency"}, XLEN'(lat), 32'd33);
    check({tag, "/busy_run"}, XLEN'(busy_bad), 32'd0);
    check(tag, out_s, exp);
    check({tag, "/busy_end"}, XLEN'(busy), 32'h0);
    check({tag, "/illegal"}, XLEN'(out_illegal), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst/out_valid", XLEN'(out_valid), 32'h0);
    check("rst/out_s", out_s, 32'h0);
    check("rst/out_illegal", XLEN'(out_illegal), 32'h0);
    check("rst/busy", XLEN'(busy), 32'h0);
    rst = 1'b0;
    #1;
    check("rst/in_ready", XLEN'(in_ready), 32'h1);

    // Back-to-back base ops, one result per cycle.
    base_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    base_op("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    base_op("sltu", OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    base_op("sub_wrap", OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    base_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    base_op("sll_mask", OP_SLL, 32'h1, 32'd33, 32'h2, 1'b0);
    base_op("srl", OP_SRL, 32'h8000_0000, 32'd31, 32'h1, 1'b0);
    base_op("or", OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    base_op("pass_b", OP_PASS_B, 32'h1234, 32'hCAFE, 32'hCAFE, 1'b0);
    tick();
    check("drain/out_valid", XLEN'(out_valid), 32'h0);

    // Multiply variants.
    run_mop("mulh", OP_MULH, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF);
    run_mop("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mop("mul", OP_MUL, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB);
    run_mop("mulhsu", OP_MULHSU, 32'd2, 32'hFFFF_FFFF, 32'h1);

    // Divide special cases and sign rules.
    run_mop("div_by0", OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_mop("remu_by0", OP_REMU, 32'd7, 32'd0, 32'd7);
    run_mop("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mop("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_mop("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_mop("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_mop("rem_negb", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'h1);
    run_mop("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_mop("remu", OP_REMU, 32'd100, 32'd7, 32'd2);

    // Backpressure: result held, pending op refused until out_ready rises.
    base_op("bp_xor", OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = OP_ADD;
    in_a      = 32'd2;
    in_b      = 32'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp/out_valid", XLEN'(out_valid), 32'h1);
      check("bp/out_s", out_s, 32'hAAAA_AAAA);
      check("bp/in_ready", XLEN'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp/in_ready_rel", XLEN'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("bp/next_valid", XLEN'(out_valid), 32'h1);
    check("bp/next_s", out_s, 32'd5);

    // Flush during cycle 10 of a DIVU.
    in_valid = 1'b1;
    in_op    = OP_DIVU;
    in_a     = 32'd100;
    in_b     = 32'd7;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_a     = 32'd2;
    in_b     = 32'd3;
    #1;
    check("flush/in_ready", XLEN'(in_ready), 32'h0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush/out_valid", XLEN'(out_valid), 32'h0);
    check("flush/busy", XLEN'(busy), 32'h0);
    check("flush/in_ready_after", XLEN'(in_ready), 32'h1);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush/no_result", XLEN'(seen), 32'd0);
    base_op("flush_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0);

    // Reset in the middle of a MUL.
    in_valid = 1'b1;
    in_op    = OP_MUL;
    in_a     = 32'd6;
    in_b     = 32'd7;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst/out_valid", XLEN'(out_valid), 32'h0);
    check("mrst/out_s", out_s, 32'h0);
    check("mrst/out_illegal", XLEN'(out_illegal), 32'h0);
    check("mrst/busy", XLEN'(busy), 32'h0);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    check("mrst/no_result", XLEN'(seen), 32'd0);

    // Undefined op codes.
    base_op("illegal12", 5'd12, 32'd5, 32'd6, 32'h0, 1'b1);
    base_op("and_clears", OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    base_op("illegal24", 5'd24, 32'd1, 32'd2, 32'h0, 1'b1);
    base_op("pass_after", OP_PASS_B, 32'd0, 32'h77, 32'h77, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
